dcache_snoop_responder: RTL and testbench

DCACHE_SNOOP_RESPONDER -- requirements
Module: dcache_snoop_responder

---
 rtl/dcache_snoop_responder.sv | 124 ++++++++++++
 tb/tb_dcache_snoop_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_snoop_responder.sv
// Snoop responder for a two-word-block data cache.
// Handles one bus snoop at a time: it looks up the line, writes it back if dirty, then invalidates or cleans it.
module dcache_snoop_responder #(
  parameter int CPUID     = 0,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  input  logic        dwait,
  input  logic        lkp_hit,
  input  logic        lkp_dirty,
  input  logic        lkp_way,
  input  logic [25:0] lkp_tag,
  input  logic [31:0] blk_word0,
  input  logic [31:0] blk_word1,
  output logic [31:0] lkp_addr,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        inv_en,
  output logic        clean_en,
  output logic        cache_stall,
  output logic        snoop_done
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB0, WB1, FINISH} state_t;

  state_t      state;
  logic [31:0] snoop_addr;
  logic        snoop_inv;
  logic        way;
  logic [25:0] tag;
  logic [31:0] word0;
  logic [31:0] word1;

  // The matched way is held only for the cache side; this logic never reads it back.
  logic unused_ok;
  assign unused_ok = ^{way, 32'(CPUID), 32'(BLK_WORDS)};

  // A snoop request wins over the cache's own traffic in the very cycle it arrives.
  assign cache_stall = ~RST & ((state != IDLE) | ccwait);
  assign lkp_addr    = (state == IDLE) ? 32'd0 : snoop_addr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      snoop_addr <= 32'd0;
      snoop_inv  <= 1'b0;
      way        <= 1'b0;
      tag        <= 26'd0;
      word0      <= 32'd0;
      word1      <= 32'd0;
      dWEN       <= 1'b0;
      daddr      <= 32'd0;
      dstore     <= 32'd0;
      inv_en     <= 1'b0;
      clean_en   <= 1'b0;
      snoop_done <= 1'b0;
    end else begin
      dWEN       <= 1'b0;
      daddr      <= 32'd0;
      dstore     <= 32'd0;
      inv_en     <= 1'b0;
      clean_en   <= 1'b0;
      snoop_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ccwait) begin
            snoop_addr <= ccsnoopaddr;
            snoop_inv  <= ccinv;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          way   <= lkp_way;
          tag   <= lkp_tag;
          word0 <= blk_word0;
          word1 <= blk_word1;
          if (lkp_hit && lkp_dirty) begin
            state  <= WB0;
            dWEN   <= 1'b1;
            daddr  <= {lkp_tag, snoop_addr[5:3], 3'b000};
            dstore <= blk_word0;
          end else begin
            // A dirty hit never reaches here, so only the invalidate pulse is possible.
            state      <= FINISH;
            snoop_done <= 1'b1;
            inv_en     <= lkp_hit & snoop_inv;
          end
        end
        WB0: begin
          dWEN <= 1'b1;
          if (dwait) begin
            daddr  <= {tag, snoop_addr[5:3], 3'b000};
            dstore <= word0;
          end else begin
            state  <= WB1;
            daddr  <= {tag, snoop_addr[5:3], 3'b100};
            dstore <= word1;
          end
        end
        WB1: begin
          if (dwait) begin
            dWEN   <= 1'b1;
            daddr  <= {tag, snoop_addr[5:3], 3'b100};
            dstore <= word1;
          end else begin
            // Written-back line: BusRdX drops it, BusRd demotes it to shared.
            state      <= FINISH;
            snoop_done <= 1'b1;
            inv_en     <= snoop_inv;
            clean_en   <= ~snoop_inv;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: a two-entry cache model answers lookups, a memory model applies dwait,
// and a scoreboard queue holds the expected writebacks and completion pulses.
module tb_dcache_snoop_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dwait = 1'b0;
  logic        lkp_hit;
  logic        lkp_dirty;
  logic        lkp_way;
  logic [25:0] lkp_tag;
  logic [31:0] blk_word0;
  logic [31:0] blk_word1;
  logic [31:0] lkp_addr;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        inv_en;
  logic        clean_en;
  logic        cache_stall;
  logic        snoop_done;

  dcache_snoop_responder #(.CPUID(0), .BLK_WORDS(2)) dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .lkp_hit(lkp_hit), .lkp_dirty(lkp_dirty), .lkp_way(lkp_way),
    .lkp_tag(lkp_tag), .blk_word0(blk_word0), .blk_word1(blk_word1), .lkp_addr(lkp_addr),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .inv_en(inv_en), .clean_en(clean_en),
    .cache_stall(cache_stall), .snoop_done(snoop_done)
  );

  always #5 CLK = ~CLK;

  // Expected events: writes carry address/data; completions carry {inv, clean} in a[1:0].
  typedef struct packed {
    logic        is_done;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   wait_lat = 0;
  int   wcnt     = 0;

  logic [31:0] t_addr [2];
  logic        t_hit  [2];
  logic        t_dirty[2];
  logic [31:0] t_w0   [2];
  logic [31:0] t_w1   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cache tag-array model, matched on block address.
  assign lkp_tag = lkp_addr[31:6];
  always_comb begin
    lkp_hit   = 1'b0;
    lkp_dirty = 1'b0;
    lkp_way   = 1'b0;
    blk_word0 = 32'd0;
    blk_word1 = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (t_hit[i] && (t_addr[i][31:3] == lkp_addr[31:3])) begin
        lkp_hit   = 1'b1;
        lkp_dirty = t_dirty[i];
        lkp_way   = i[0];
        blk_word0 = t_w0[i];
        blk_word1 = t_w1[i];
      end
    end
  end

  task automatic set_entry(input int i, input logic [31:0] a, input logic h, input logic d,
                           input logic [31:0] w0, input logic [31:0] w1);
    t_addr[i] = a; t_hit[i] = h; t_dirty[i] = d; t_w0[i] = w0; t_w1[i] = w1;
  endtask

  // Pushes the expected events of one snoop and returns its cycle count from the sampling edge.
  task automatic push_expect(input logic [31:0] addr, input logic inv, output int lat);
    logic h, d;
    logic [31:0] w0, w1;
    exp_t e;
    h = 0; d = 0; w0 = 0; w1 = 0;
    for (int i = 0; i < 2; i++)
      if (t_hit[i] && (t_addr[i][31:3] == addr[31:3])) begin
        h = 1; d = t_dirty[i]; w0 = t_w0[i]; w1 = t_w1[i];
      end
    if (h && d) begin
      e.is_done = 0; e.a = {addr[31:3], 3'b000}; e.d = w0; sb.push_back(e);
      e.is_done = 0; e.a = {addr[31:3], 3'b100}; e.d = w1; sb.push_back(e);
      lat = 4 + 2 * wait_lat;
    end else begin
      lat = 2;
    end
    e.is_done = 1; e.a = {30'd0, h & inv, h & ~inv & d}; e.d = 32'd0;
    sb.push_back(e);
  endtask

  // Memory model: holds dwait high for wait_lat cycles of each write.
  always @(posedge CLK or posedge RST) begin
    if (RST) wcnt = 0;
    else if (dWEN) begin
      if (dwait) wcnt++;
      else wcnt = 0;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      dwait = dWEN && (wcnt < wait_lat);
      check("pulse_exclusive", 32'(inv_en & clean_en), 32'd0);
      if (dWEN && !dwait) begin
        if (sb.size() == 0 || sb[0].is_done) check("unexpected_wr", daddr, 32'hFFFF_FFFF);
        else begin
          mon_e = sb.pop_front();
          $display("write  addr=%h data=%h", daddr, dstore);
          check("wr_addr", daddr, mon_e.a);
          check("wr_data", dstore, mon_e.d);
        end
      end
      if (snoop_done) begin
        if (sb.size() == 0 || !sb[0].is_done) check("unexpected_done", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          $display("done   inv_en=%0d clean_en=%0d", inv_en, clean_en);
          check("done_inv", 32'(inv_en), 32'(mon_e.a[1]));
          check("done_clean", 32'(clean_en), 32'(mon_e.a[0]));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge with the block back in IDLE.
  task automatic run_snoop(input string name, input logic [31:0] addr, input logic inv, input int lat_cfg);
    int exp_lat, cyc;
    wait_lat = lat_cfg;
    push_expect(addr, inv, exp_lat);
    ccwait = 1; ccsnoopaddr = addr; ccinv = inv;
    #1;
    check({name, "_stall_req"}, 32'(cache_stall), 32'd1);
    @(posedge CLK); #1;
    ccwait = 0; ccsnoopaddr = ~addr; ccinv = ~inv;
    check({name, "_lkp_addr"}, lkp_addr, addr);
    cyc = 1;
    while (!snoop_done && cyc < 60) begin
      check({name, "_stall_busy"}, 32'(cache_stall), 32'd1);
      @(posedge CLK); #1;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    @(posedge CLK); #1;
    check({name, "_idle_stall"}, 32'(cache_stall), 32'd0);
    check({name, "_idle_lkp"}, lkp_addr, 32'd0);
  endtask

  initial begin
    int dones, seen2, lat_unused;
    RST = 1; ccwait = 1; ccinv = 1; ccsnoopaddr = 32'h0000_0048;
    set_entry(0, 32'h0000_1234, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    set_entry(1, 32'h0000_2000, 1, 0, 32'h1111_1111, 32'h2222_2222);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dwen", 32'(dWEN), 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    check("rst_lkp_addr", lkp_addr, 32'd0);
    check("rst_stall", 32'(cache_stall), 32'd0);
    check("rst_pulses", 32'({inv_en, clean_en, snoop_done}), 32'd0);
    ccwait = 0; ccinv = 0;
    @(posedge CLK); #1;
    RST = 0;

    run_snoop("clean_miss", 32'h0000_0048, 0, 0);
    run_snoop("dirty_busrd", 32'h0000_1234, 0, 3);
    run_snoop("dirty_busrdx", 32'h0000_1234, 1, 3);
    run_snoop("clean_hit_inv", 32'h0000_2000, 1, 0);
    run_snoop("clean_hit_rd", 32'h0000_2000, 0, 2);
    set_entry(1, 32'h0000_3008, 1, 1, 32'h0BAD_F00D, 32'h1234_5678);
    run_snoop("dirty_fast", 32'h0000_300C, 0, 0);

    // Reset while the second writeback word is outstanding.
    wait_lat = 3;
    push_expect(32'h0000_1234, 0, lat_unused);
    ccwait = 1; ccsnoopaddr = 32'h0000_1234; ccinv = 0;
    @(posedge CLK); #1;
    ccwait = 0;
    for (int c = 0; c < 30 && !(dWEN && daddr[2]); c++) begin
      @(posedge CLK); #1;
    end
    check("rst_mid_in_wb1", 32'(dWEN & daddr[2]), 32'd1);
    #1 RST = 1;
    #1;
    check("rst_mid_dwen", 32'(dWEN), 32'd0);
    check("rst_mid_daddr", daddr, 32'd0);
    check("rst_mid_idle", lkp_addr, 32'd0);
    check("rst_mid_done", 32'(snoop_done), 32'd0);
    check("rst_mid_stall", 32'(cache_stall), 32'd0);
    sb.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    run_snoop("post_rst_miss", 32'h0000_0048, 1, 0);

    // Back-to-back snoops with ccwait held high throughout.
    set_entry(0, 32'h0000_0040, 1, 0, 32'hAAAA_0000, 32'hAAAA_0001);
    set_entry(1, 32'h0000_0080, 1, 1, 32'hBBBB_0000, 32'hBBBB_0001);
    wait_lat = 1;
    push_expect(32'h0000_0040, 0, lat_unused);
    push_expect(32'h0000_0080, 0, lat_unused);
    ccwait = 1; ccsnoopaddr = 32'h0000_0040; ccinv = 0;
    @(posedge CLK); #1;
    ccsnoopaddr = 32'h0000_0080;
    dones = 0; seen2 = 0;
    for (int c = 0; c < 40 && dones < 2; c++) begin
      check("b2b_stall", 32'(cache_stall), 32'd1);
      if (lkp_addr == 32'h0000_0080 && seen2 == 0) begin
        seen2 = 1;
        ccwait = 0;
      end
      if (snoop_done) dones++;
      @(posedge CLK); #1;
    end
    check("b2b_dones", 32'(dones), 32'd2);
    check("b2b_second_lookup", 32'(seen2), 32'd1);
    ccwait = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
